// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin sharing of one UART transmitter between NUM_REQ byte producers.
//   A byte is taken over a valid/ready handshake and goes to the transmitter
//   as a one-clock tx_dv strobe. tx_byte stays stable until the next accept.
//   After the byte is issued the block waits for tx_done, then idles for GAP_CLKS.
//   A watchdog returns the block to IDLE if tx_done never arrives.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester "byte available"
//   req_data     requester i byte at [8*i+7:8*i]
//   req_ready    one-hot accept, combinational, only in IDLE
//   tx_dv        one-clock start strobe to the transmitter
//   tx_byte      byte being transmitted
//   tx_active    transmitter busy status (mirrored into busy)
//   tx_done      transmitter finished the current frame
//   grant_id     requester whose byte is in flight / last sent
//   busy         block not idle, or transmitter active
//   timeout_err  one-clock pulse when the watchdog aborts a frame
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4774,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  // The counter serves the watchdog and the gap. One spare bit means the
  // increment on the final cycle of either phase cannot wrap.
  localparam int CMAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [GW-1:0]        rr_ptr;
  logic [CW-1:0]        cnt;
  logic [GW-1:0]        pick;
  logic [GW-1:0]        next_ptr;
  logic                 found;
  logic                 accept;
  logic                 wd_expire;
  logic                 gap_last;
  logic [NUM_REQ-1:0]   ready_vec;
  logic [7:0]           req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin pick. The first pass finds the lowest valid index overall,
  // which is the wrap-around candidate. The second pass overrides it with
  // the lowest valid index at or above rr_ptr, when one exists.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        pick  = GW'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr))) begin
        pick = GW'(i);
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_vec[i] = found && (pick == GW'(i));
    end
  end

  assign next_ptr  = (int'(pick) == NUM_REQ - 1) ? GW'(0) : pick + GW'(1);
  assign accept    = (state == S_IDLE) && found;
  assign wd_expire = (cnt == CW'(TIMEOUT_CLKS - 1));
  assign gap_last  = (cnt == CW'(GAP_CLKS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A tx_done during ISSUE belongs to an older frame, so
  // ISSUE ignores it. In WAIT, tx_done is tested before the watchdog so
  // that it wins when both occur in the same clock.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (found) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          state_nx = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
        end else if (wd_expire) begin
          state_nx = S_IDLE;
        end
      end
      S_GAP:   if (gap_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic. req_ready is held low during reset even though the
  // state register already reads IDLE at that point.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE)) begin
      req_ready = ready_vec;
    end
    busy = (state != S_IDLE) || tx_active;
  end

  // Registered outputs, pointer and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      tx_dv       <= 1'b0;
      tx_byte     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      tx_dv       <= accept;
      timeout_err <= (state == S_WAIT) && !tx_done && wd_expire;
      if (accept) begin
        tx_byte  <= req_bytes[pick];
        grant_id <= pick;
        rr_ptr   <= next_ptr;
      end
      case (state)
        S_ISSUE: cnt <= '0;
        S_WAIT:  cnt <= tx_done ? '0 : cnt + CW'(1);
        S_GAP:   cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter (NUM_REQ=4, GAP_CLKS=5, TIMEOUT_CLKS=50).
// A timeline model predicts every output on every falling edge. Directed
// sections pin literal values, and a randomized section follows them.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GW  = 2;
  localparam int GAP = 5;
  localparam int TO  = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_active;
  logic           tx_done = 1'b0;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Transmitter emulator controls
  int tx_delay    = 3;
  bit issue_pulse = 1'b0;
  bit noise       = 1'b0;
  int tx_cnt      = -1;
  bit tx_busy_q   = 1'b0;
  logic [N-1:0] acc_q;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) acc_q <= req_valid & req_ready;
  assign tx_active = tx_busy_q & rst_n;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] lane(input logic [8*N-1:0] v, input int i);
    return 8'(v >> (8*i));
  endfunction

  task automatic set_lane(input int i, input logic [7:0] b);
    logic [8*N-1:0] m;
    m = {{(8*N-8){1'b0}}, 8'hFF} << (8*i);
    req_data = (req_data & ~m) | ({{(8*N-8){1'b0}}, b} << (8*i));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Transmitter: on tx_dv, raise tx_done tx_delay clocks later (never if negative).
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_cnt = -1;
    end else if (tx_dv) begin
      tx_cnt = tx_delay;
      if (issue_pulse) tx_done = 1'b1;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_cnt  = -1;
      end
    end
    if (noise && rst_n && ($urandom_range(0, 15) == 0)) tx_done = 1'b1;
    tx_busy_q = (tx_cnt >= 0);
  end

  // Timeline model. Accept in cycle a gives tx_dv in cycle a+1; the watch
  // for tx_done runs from a+2 to a+1+TO. tx_done in cycle d returns to idle
  // at d+1+GAP. A timeout returns to idle, with the error pulse, at a+2+TO.
  int              m_ptr, m_acc, m_idle_at, m_err_cyc;
  bit              m_inflight, m_resolved;
  logic [7:0]      m_byte;
  logic [GW-1:0]   m_gid;

  always @(negedge clk) begin : compare
    logic [N-1:0] e_ready;
    bit           idle;
    int           li;
    if (!rst_n) begin
      m_ptr = 0; m_inflight = 1'b0; m_resolved = 1'b0; m_acc = -10;
      m_idle_at = -1; m_err_cyc = -1; m_byte = '0; m_gid = '0;
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_tx_dv", 32'(tx_dv), 0);
      check("rst_tx_byte", 32'(tx_byte), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      check("rst_busy", 32'(busy), 0);
    end else begin
      if (m_inflight && m_idle_at >= 0 && cyc >= m_idle_at) m_inflight = 1'b0;
      idle = !m_inflight;
      e_ready = '0;
      if (idle) begin
        for (int k = 0; k < N; k++) begin
          li = (m_ptr + k) % N;
          if (e_ready == '0 && req_valid[GW'(li)]) e_ready[GW'(li)] = 1'b1;
        end
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("tx_dv", 32'(tx_dv), 32'(m_inflight && (cyc == m_acc + 1)));
      check("tx_byte", 32'(tx_byte), 32'(m_byte));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("busy", 32'(busy), 32'(!idle || tx_active));
      check("timeout_err", 32'(timeout_err), 32'(cyc == m_err_cyc));
      if (m_inflight && !m_resolved && cyc >= m_acc + 2) begin
        if (tx_done) begin
          m_resolved = 1'b1;
          m_idle_at  = cyc + 1 + GAP;
        end else if (cyc == m_acc + 1 + TO) begin
          m_resolved = 1'b1;
          m_idle_at  = cyc + 1;
          m_err_cyc  = cyc + 1;
        end
      end
      if (e_ready != '0) begin
        for (int i = 0; i < N; i++) begin
          if (e_ready[GW'(i)]) begin
            m_gid  = GW'(i);
            m_byte = lane(req_data, i);
            m_ptr  = (i + 1) % N;
          end
        end
        m_inflight = 1'b1; m_resolved = 1'b0; m_acc = cyc; m_idle_at = -1;
      end
    end
  end

  task automatic wait_ready(output int idx);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 300) begin
      tick(); #1; n++;
    end
    check("wait_ready_bound", 32'(req_ready != '0), 1);
    idx = -1;
    for (int i = 0; i < N; i++) if (req_ready[GW'(i)]) idx = i;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      tick(); n++;
    end
    check("idle_bound", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a, n, idx, c_done, c_rdy, c_err;
    bit err_seen;
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single byte from requester 1
    tick();
    tx_delay = 20;
    req_valid = 4'b0010; set_lane(1, 8'hA5);
    #1 check("t2_req_ready", 32'(req_ready), 'h2);
    tick(); req_valid = '0;
    #1;
    check("t2_tx_dv", 32'(tx_dv), 1);
    check("t2_tx_byte", 32'(tx_byte), 'hA5);
    check("t2_grant_id", 32'(grant_id), 1);
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
    check("t2_busy_clks", n, 26);

    // Reset in the middle of WAIT_DONE
    tx_delay = 30;
    req_valid = 4'b0100; set_lane(2, 8'h3C);
    #1 check("t1_req_ready", 32'(req_ready), 'h4);
    tick(); req_valid = '0;
    repeat (4) tick();
    for (int i = 0; i < N; i++) set_lane(i, 8'h10 + 8'(i));
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("t1_rst_req_ready", 32'(req_ready), 0);
    check("t1_rst_tx_dv", 32'(tx_dv), 0);
    check("t1_rst_tx_byte", 32'(tx_byte), 0);
    check("t1_rst_grant_id", 32'(grant_id), 0);
    check("t1_rst_timeout_err", 32'(timeout_err), 0);
    check("t1_rst_busy", 32'(busy), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1 check("t1_first_after_reset", 32'(req_ready), 'h1);

    // Fairness with all valids held
    tx_delay = 3;
    for (int k = 0; k < 8; k++) begin
      wait_ready(idx);
      check("t3_grant_order", idx, k % 4);
      tick();
      #1;
      check("t3_tx_byte", 32'(tx_byte), 32'(8'h10 + 8'(k % 4)));
      check("t3_grant_id", 32'(grant_id), k % 4);
    end
    req_valid = '0;
    wait_idle();

    // Gap between tx_done and the next req_ready
    tx_delay = 4;
    req_valid = 4'b0101; set_lane(0, 8'h41); set_lane(2, 8'h42);
    wait_ready(idx);
    check("t4_first_grant", idx, 0);
    tick(); req_valid[0] = 1'b0;
    c_done = -1; c_rdy = -1; n = 0;
    while (c_rdy < 0 && n < 100) begin
      #1;
      if (tx_done && c_done < 0) c_done = cyc;
      if (req_ready != '0) c_rdy = cyc;
      if (c_rdy < 0) tick();
      n++;
    end
    check("t4_gap_clks", c_rdy - c_done - 1, 5);
    check("t4_second_ready", 32'(req_ready), 'h4);
    tick(); req_valid = '0;
    wait_idle();

    // Watchdog timeout
    tx_delay = -1;
    req_valid = 4'b1000; set_lane(3, 8'h77);
    #1 check("t5_req_ready", 32'(req_ready), 'h8);
    a = cyc;
    tick(); req_valid = '0;
    c_err = -1; n = 0;
    while (c_err < 0 && n < 200) begin
      #1;
      if (timeout_err) c_err = cyc;
      else tick();
      n++;
    end
    check("t5_wait_clks", c_err - a - 2, 50);
    tx_delay = 3;
    req_valid = 4'b0001; set_lane(0, 8'h88);
    #1 check("t5_regrant_ready", 32'(req_ready), 'h1);
    tick(); req_valid = '0;
    #1;
    check("t5_err_one_clk", 32'(timeout_err), 0);
    check("t5_regrant_dv", 32'(tx_dv), 1);
    wait_idle();

    // tx_done during ISSUE is ignored
    issue_pulse = 1'b1; tx_delay = 10;
    req_valid = 4'b0010; set_lane(1, 8'h5A);
    #1 check("t6_req_ready", 32'(req_ready), 'h2);
    tick(); req_valid = '0; issue_pulse = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
    check("t6_issue_done_ignored", n, 16);

    // tx_done in the same clock as the timeout: no error
    tx_delay = 50;
    req_valid = 4'b0100; set_lane(2, 8'hC3);
    #1 check("t6_req_ready2", 32'(req_ready), 'h4);
    tick(); req_valid = '0;
    n = 0; err_seen = 1'b0;
    while (busy && n < 200) begin
      n++; tick();
      if (timeout_err) err_seen = 1'b1;
    end
    check("t6_coincide_no_err", 32'(err_seen), 0);
    check("t6_coincide_busy_clks", n, 56);

    // Randomized traffic, with one reset in the middle
    noise = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      tick();
      tx_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 60));
      if (t == 1500) rst_n = 1'b0;
      if (t == 1503) rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (acc_q[GW'(i)]) begin
          req_valid[GW'(i)] = 1'b0;
        end else if (req_valid[GW'(i)] && ($urandom_range(0, 63) == 0)) begin
          req_valid[GW'(i)] = 1'b0;
        end else if (!req_valid[GW'(i)] && ($urandom_range(0, 3) == 0)) begin
          req_valid[GW'(i)] = 1'b1;
          set_lane(i, 8'($urandom));
        end
      end
    end
    noise = 1'b0; req_valid = '0; tx_delay = 3;
    repeat (2) tick();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
